// File: rtl/rf_initiator.sv
// Register-file initiator: turns read-pair / write / write-verify commands into
// one-cycle register-file accesses and returns a single response per command.
module rf_initiator #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_op,
   input  logic [ADDR_WIDTH-1:0] cmd_addr1,
   input  logic [ADDR_WIDTH-1:0] cmd_addr2,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_data1,
   output logic [DATA_WIDTH-1:0] rsp_data2,
   output logic                  rsp_mismatch,
   output logic [DATA_WIDTH-1:0] rf_din,
   output logic [ADDR_WIDTH-1:0] rf_wad1,
   output logic [ADDR_WIDTH-1:0] rf_rad1,
   output logic [ADDR_WIDTH-1:0] rf_rad2,
   output logic                  rf_wen1,
   output logic                  rf_ren1,
   output logic                  rf_ren2,
   input  logic [DATA_WIDTH-1:0] rf_dout1,
   input  logic [DATA_WIDTH-1:0] rf_dout2,
   input  logic                  rf_collision,
   output logic                  busy,
   output logic [7:0]            coll_cnt
);

   localparam logic [1:0] OP_RD  = 2'b00;
   localparam logic [1:0] OP_WR  = 2'b01;
   localparam logic [1:0] OP_WV  = 2'b10;
   localparam logic [1:0] OP_RSV = 2'b11;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WRITE = 3'd1,
      READ  = 3'd2,
      WAIT  = 3'd3,
      RESP  = 3'd4
   } state_t;

   state_t                state_r, state_next_s;
   logic [1:0]            op_r;
   logic [ADDR_WIDTH-1:0] addr1_r, addr2_r;
   logic [DATA_WIDTH-1:0] wdata_r;

   logic                  cmd_ready_r, rsp_valid_r, rsp_mismatch_r, busy_r;
   logic [DATA_WIDTH-1:0] rsp_data1_r, rsp_data2_r, rf_din_r;
   logic [ADDR_WIDTH-1:0] rf_wad1_r, rf_rad1_r, rf_rad2_r;
   logic                  rf_wen1_r, rf_ren1_r, rf_ren2_r;
   logic [7:0]            coll_cnt_r;

   logic                  accept_s;
   logic [1:0]            op_s;
   logic [ADDR_WIDTH-1:0] addr1_s, addr2_s;
   logic [DATA_WIDTH-1:0] wdata_s;
   logic                  rf_wen1_s, rf_ren1_s, rf_ren2_s;
   logic [DATA_WIDTH-1:0] rf_din_s, rsp_data1_s, rsp_data2_s;
   logic [ADDR_WIDTH-1:0] rf_wad1_s, rf_rad1_s, rf_rad2_s;
   logic                  rsp_mismatch_s;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      if (v == 8'd255) begin
         return v;
      end else begin
         return v + 8'd1;
      end
   endfunction

   assign accept_s = (state_r == IDLE) && cmd_valid;

   // Command fields: live inputs in the accept cycle, latched copy afterwards.
   always_comb begin
      if (state_r == IDLE) begin
         op_s    = cmd_op;
         addr1_s = cmd_addr1;
         addr2_s = cmd_addr2;
         wdata_s = cmd_wdata;
      end else begin
         op_s    = op_r;
         addr1_s = addr1_r;
         addr2_s = addr2_r;
         wdata_s = wdata_r;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (cmd_valid) begin
               case (cmd_op)
                  OP_RD:   state_next_s = READ;
                  OP_WR:   state_next_s = WRITE;
                  OP_WV:   state_next_s = WRITE;
                  OP_RSV:  state_next_s = RESP;
                  default: state_next_s = IDLE;
               endcase
            end else begin
               state_next_s = IDLE;
            end
         end
         WRITE:   state_next_s = (op_r == OP_WV) ? READ : RESP;
         READ:    state_next_s = WAIT;
         WAIT:    state_next_s = RESP;
         RESP: begin
            if (rsp_ready) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = RESP;
            end
         end
         default: state_next_s = IDLE;
      endcase
   end

   // Register-file drive for the upcoming cycle; outputs are registered so the
   // enables line up exactly with the WRITE / READ state cycles.
   always_comb begin
      rf_wen1_s = 1'b0;
      rf_ren1_s = 1'b0;
      rf_ren2_s = 1'b0;
      rf_din_s  = rf_din_r;
      rf_wad1_s = rf_wad1_r;
      rf_rad1_s = rf_rad1_r;
      rf_rad2_s = rf_rad2_r;
      case (state_next_s)
         WRITE: begin
            rf_wen1_s = 1'b1;
            rf_wad1_s = addr1_s;
            rf_din_s  = wdata_s;
         end
         READ: begin
            rf_ren1_s = 1'b1;
            rf_rad1_s = addr1_s;
            if (op_s == OP_RD) begin
               rf_ren2_s = 1'b1;
               rf_rad2_s = addr2_s;
            end else begin
               rf_ren2_s = 1'b0;
            end
         end
         default: begin
            rf_wen1_s = 1'b0;
         end
      endcase
   end

   // Response payload: captured from the RF at the end of WAIT, zeroed when
   // entering RESP by any other path, otherwise held.
   always_comb begin
      rsp_data1_s    = rsp_data1_r;
      rsp_data2_s    = rsp_data2_r;
      rsp_mismatch_s = rsp_mismatch_r;
      if (state_r == WAIT) begin
         rsp_data1_s    = rf_dout1;
         rsp_data2_s    = (op_r == OP_RD) ? rf_dout2 : '0;
         rsp_mismatch_s = (op_r == OP_WV) ? (rf_dout1 != wdata_r) : 1'b0;
      end else if ((state_next_s == RESP) && (state_r != RESP)) begin
         rsp_data1_s    = '0;
         rsp_data2_s    = '0;
         rsp_mismatch_s = (op_s == OP_RSV);
      end else begin
         rsp_mismatch_s = rsp_mismatch_r;
      end
   end

   // State, latched command and all registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r        <= IDLE;
         op_r           <= 2'b00;
         addr1_r        <= '0;
         addr2_r        <= '0;
         wdata_r        <= '0;
         cmd_ready_r    <= 1'b1;
         busy_r         <= 1'b0;
         rsp_valid_r    <= 1'b0;
         rsp_data1_r    <= '0;
         rsp_data2_r    <= '0;
         rsp_mismatch_r <= 1'b0;
         rf_wen1_r      <= 1'b0;
         rf_ren1_r      <= 1'b0;
         rf_ren2_r      <= 1'b0;
         rf_din_r       <= '0;
         rf_wad1_r      <= '0;
         rf_rad1_r      <= '0;
         rf_rad2_r      <= '0;
         coll_cnt_r     <= 8'd0;
      end else begin
         state_r <= state_next_s;
         if (accept_s) begin
            op_r    <= cmd_op;
            addr1_r <= cmd_addr1;
            addr2_r <= cmd_addr2;
            wdata_r <= cmd_wdata;
         end
         cmd_ready_r    <= (state_next_s == IDLE);
         busy_r         <= (state_next_s != IDLE);
         rsp_valid_r    <= (state_next_s == RESP);
         rsp_data1_r    <= rsp_data1_s;
         rsp_data2_r    <= rsp_data2_s;
         rsp_mismatch_r <= rsp_mismatch_s;
         rf_wen1_r      <= rf_wen1_s;
         rf_ren1_r      <= rf_ren1_s;
         rf_ren2_r      <= rf_ren2_s;
         rf_din_r       <= rf_din_s;
         rf_wad1_r      <= rf_wad1_s;
         rf_rad1_r      <= rf_rad1_s;
         rf_rad2_r      <= rf_rad2_s;
         if (rf_collision) begin
            coll_cnt_r <= sat_inc8(coll_cnt_r);
         end
      end
   end

   assign cmd_ready    = cmd_ready_r;
   assign busy         = busy_r;
   assign rsp_valid    = rsp_valid_r;
   assign rsp_data1    = rsp_data1_r;
   assign rsp_data2    = rsp_data2_r;
   assign rsp_mismatch = rsp_mismatch_r;
   assign rf_wen1      = rf_wen1_r;
   assign rf_ren1      = rf_ren1_r;
   assign rf_ren2      = rf_ren2_r;
   assign rf_din       = rf_din_r;
   assign rf_wad1      = rf_wad1_r;
   assign rf_rad1      = rf_rad1_r;
   assign rf_rad2      = rf_rad2_r;
   assign coll_cnt     = coll_cnt_r;

endmodule

// File: tb/tb_rf_initiator.sv
// Scoreboard bench for rf_initiator: directed commands against a synchronous
// register-file model; a negedge monitor pops expected responses.
module tb_rf_initiator;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = 2'b00;
   logic [4:0]  cmd_addr1 = 5'd0, cmd_addr2 = 5'd0;
   logic [15:0] cmd_wdata = 16'h0000;
   logic        rsp_valid, rsp_mismatch;
   logic        rsp_ready = 1'b1;
   logic [15:0] rsp_data1, rsp_data2, rf_din;
   logic [4:0]  rf_wad1, rf_rad1, rf_rad2;
   logic        rf_wen1, rf_ren1, rf_ren2;
   logic [15:0] rf_dout1 = 16'h0000, rf_dout2 = 16'h0000;
   logic        rf_collision = 1'b0;
   logic        busy;
   logic [7:0]  coll_cnt;

   logic        corrupt = 1'b0;
   logic [15:0] mem [32] = '{default: 16'h0000};

   int tests = 0, fails = 0;
   int wen_cnt = 0, ren_cnt = 0, overlap = 0, rsp_cnt = 0;
   logic [32:0] exp_q [$];

   rf_initiator #(.DATA_WIDTH(16), .ADDR_WIDTH(5)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr1(cmd_addr1), .cmd_addr2(cmd_addr2), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data1(rsp_data1),
      .rsp_data2(rsp_data2), .rsp_mismatch(rsp_mismatch),
      .rf_din(rf_din), .rf_wad1(rf_wad1), .rf_rad1(rf_rad1), .rf_rad2(rf_rad2),
      .rf_wen1(rf_wen1), .rf_ren1(rf_ren1), .rf_ren2(rf_ren2),
      .rf_dout1(rf_dout1), .rf_dout2(rf_dout2), .rf_collision(rf_collision),
      .busy(busy), .coll_cnt(coll_cnt)
   );

   always #5 clk = ~clk;

   // Register-file model: synchronous write, registered read, optional bit-0 fault on port 1.
   always @(posedge clk) begin
      if (rf_wen1) mem[rf_wad1] <= rf_din;
      if (rf_ren1) rf_dout1 <= mem[rf_rad1] ^ {15'd0, corrupt};
      if (rf_ren2) rf_dout2 <= mem[rf_rad2];
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: enable bookkeeping and scoreboard pop on each response handshake.
   always @(negedge clk) begin
      if (!reset) begin
         if (rf_wen1) wen_cnt++;
         if (rf_ren1 || rf_ren2) ren_cnt++;
         if (rf_wen1 && (rf_ren1 || rf_ren2)) overlap++;
         if (rsp_valid && rsp_ready) begin
            rsp_cnt++;
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_rsp: got %0h/%0h/%0b, expected none",
                        rsp_data1, rsp_data2, rsp_mismatch);
            end else begin
               check("rsp", {31'd0, rsp_data1, rsp_data2, rsp_mismatch}, {31'd0, exp_q.pop_front()});
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns in the first cycle after the accept edge.
   task automatic send(input logic [1:0] op, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [15:0] wd);
      int n = 0;
      cmd_op = op; cmd_addr1 = a1; cmd_addr2 = a2; cmd_wdata = wd;
      cmd_valid = 1'b1;
      while (!cmd_ready && n < 50) begin
         tick();
         n++;
      end
      if (!cmd_ready) check("cmd_accept_timeout", 64'd0, 64'd1);
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 50) begin
         tick();
         n++;
      end
      check("idle_timeout", {63'd0, busy}, 64'd0);
   endtask

   task automatic lat(input logic [1:0] op, input logic [4:0] a1, input logic [4:0] a2,
                      input logic [15:0] wd, input int exp_lat, input logic [32:0] exp_rsp);
      int k = 1;
      exp_q.push_back(exp_rsp);
      send(op, a1, a2, wd);
      while (!rsp_valid && k < 20) begin
         tick();
         k++;
      end
      check($sformatf("latency_op%0d", op), 64'(k), 64'(exp_lat));
      tick();
      check("cmd_ready_after_hs", {63'd0, cmd_ready}, 64'd1);
   endtask

   initial begin
      int w0, e0, r0, n, vc;
      tick(); tick();
      reset = 1'b0;
      // reset state
      check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
      check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_coll_cnt", {56'd0, coll_cnt}, 64'd0);
      check("rst_rf", {29'd0, rf_din, rf_wad1, rf_rad1, rf_rad2, rf_wen1, rf_ren1, rf_ren2,
                       rsp_data1[2:0]}, 64'd0);

      // write then read-pair
      w0 = wen_cnt;
      exp_q.push_back({16'h0000, 16'h0000, 1'b0});
      send(2'b01, 5'd7, 5'd0, 16'hA5A5);
      wait_idle();
      check("wen_pulses", 64'(wen_cnt - w0), 64'd1);
      exp_q.push_back({16'hA5A5, 16'h0000, 1'b0});
      send(2'b00, 5'd7, 5'd3, 16'h0000);
      wait_idle();

      // write-verify pass and fail
      exp_q.push_back({16'hFFFF, 16'h0000, 1'b0});
      send(2'b10, 5'd4, 5'd0, 16'hFFFF);
      wait_idle();
      corrupt = 1'b1;
      exp_q.push_back({16'hFFFE, 16'h0000, 1'b1});
      send(2'b10, 5'd4, 5'd0, 16'hFFFF);
      wait_idle();
      corrupt = 1'b0;

      // latency per op (cycle 1 = first cycle after the accept edge)
      lat(2'b00, 5'd7, 5'd4, 16'h0000, 3, {16'hA5A5, 16'hFFFF, 1'b0});
      lat(2'b01, 5'd10, 5'd0, 16'h1111, 2, {16'h0000, 16'h0000, 1'b0});
      lat(2'b10, 5'd10, 5'd0, 16'h2222, 4, {16'h2222, 16'h0000, 1'b0});

      // backpressure with a held command
      rsp_ready = 1'b0;
      exp_q.push_back({16'hA5A5, 16'h2222, 1'b0});
      send(2'b00, 5'd7, 5'd10, 16'h0000);
      n = 0;
      while (!rsp_valid && n < 20) begin
         tick();
         n++;
      end
      cmd_op = 2'b01; cmd_addr1 = 5'd9; cmd_wdata = 16'h1234; cmd_valid = 1'b1;
      w0 = wen_cnt;
      r0 = rsp_cnt;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_valid", {63'd0, rsp_valid}, 64'd1);
         check("bp_data", {32'd0, rsp_data1, rsp_data2}, {32'd0, 16'hA5A5, 16'h2222});
         check("bp_cmd_ready", {63'd0, cmd_ready}, 64'd0);
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      repeat (4) tick();
      check("bp_one_rsp", 64'(rsp_cnt - r0), 64'd1);
      check("bp_no_write", 64'(wen_cnt - w0), 64'd0);

      // collision counter saturation
      rf_collision = 1'b1;
      repeat (10) tick();
      check("coll_10", {56'd0, coll_cnt}, 64'd10);
      repeat (290) tick();
      check("coll_sat", {56'd0, coll_cnt}, 64'd255);
      rf_collision = 1'b0;
      tick();
      check("coll_hold", {56'd0, coll_cnt}, 64'd255);

      // reserved op
      e0 = wen_cnt + ren_cnt;
      exp_q.push_back({16'h0000, 16'h0000, 1'b1});
      send(2'b11, 5'd5, 5'd5, 16'h5555);
      wait_idle();
      check("rsv_no_enables", 64'(wen_cnt + ren_cnt - e0), 64'd0);

      // reset during READ
      send(2'b00, 5'd7, 5'd3, 16'h0000);
      check("in_read_ren1", {63'd0, rf_ren1}, 64'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_rst_enables", {61'd0, rf_wen1, rf_ren1, rf_ren2}, 64'd0);
      check("mid_rst_state", {53'd0, rsp_valid, busy, cmd_ready, coll_cnt}, {53'd0, 3'b001, 8'd0});
      vc = 0;
      for (int i = 0; i < 6; i++) begin
         if (rsp_valid) vc++;
         tick();
      end
      check("mid_rst_no_rsp", 64'(vc), 64'd0);
      exp_q.push_back({16'hA5A5, 16'hFFFF, 1'b0});
      send(2'b00, 5'd7, 5'd4, 16'h0000);
      wait_idle();

      repeat (3) tick();
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      check("no_wen_ren_overlap", 64'(overlap), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
